cceip_kernel_example_axi_mem_responder: RTL and testbench

AXI4 memory responder (slave) that terminates the AXI4 master port driven by the cceip example kernel: it accepts read and write burst requests, backs them with an on-chip word-addressed memory, returns read data beats and issues write responses. Used as the far-end model of host/device memory in kernel-level simulation and as a loopback target in on-chip bring-up builds. Read and write channels are independent engines sharing one dual-port memory.

---
 rtl/cceip_kernel_example_axi_mem_responder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_cceip_kernel_example_axi_mem_responder.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cceip_kernel_example_axi_mem_responder.sv
// ----------------------------------------------------------------------------
// cceip_kernel_example_axi_mem_responder
//
// Purpose:
//   AXI4 slave that terminates the cceip example kernel's master port. It
//   backs read and write INCR bursts with an on-chip word-addressed memory,
//   returns read beats and issues write responses (always OKAY). The read and
//   write engines are independent and share one dual-port memory that is
//   read-first when both sides touch the same word in the same cycle.
//
// Ports:
//   aclk, areset                  clock, synchronous active-high reset
//   s_axi_aw*                     write address channel (addr, len, valid/ready)
//   s_axi_w*                      write data channel (data, strb, last, valid/ready)
//   s_axi_b*                      write response channel (valid/ready)
//   s_axi_ar*                     read address channel (addr, len, valid/ready)
//   s_axi_r*                      read data channel (data, last, valid/ready)
//   stat_wlast_err                sticky wlast protocol mismatch flag
// ----------------------------------------------------------------------------
module cceip_kernel_example_axi_mem_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                            aclk,
    input  logic                            areset,

    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                      s_axi_awlen,

    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wlast,

    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,

    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                      s_axi_arlen,

    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic                            s_axi_rlast,

    output logic                            stat_wlast_err
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(C_MEM_DEPTH_WORDS);

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_DATA,
        WR_RESP
    } wr_state_t;

    // Backing store; intentionally never reset.
    logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH_WORDS];

    // Byte-offset bits and address bits above the memory depth are ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    // ------------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------------
    wr_state_t         r_wr_state;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic              r_wlast_err;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [7:0]        r_wr_len;
    logic [7:0]        r_wr_cnt;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_w_final;

    assign w_aw_hs   = s_axi_awvalid && r_awready;
    assign w_w_hs    = s_axi_wvalid && r_wready;
    assign w_w_final = (r_wr_cnt == r_wr_len);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_state  <= WR_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_aw_hs) begin
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wr_state <= WR_DATA;
                    end else begin
                        // Comes up the first cycle after reset release.
                        r_awready <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_w_hs) begin
                        // Burst length comes from awlen; wlast is only audited.
                        if (s_axi_wlast != w_w_final) begin
                            r_wlast_err <= 1'b1;
                        end
                        if (w_w_final) begin
                            r_wready   <= 1'b0;
                            r_bvalid   <= 1'b1;
                            r_wr_state <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid   <= 1'b0;
                        r_awready  <= 1'b1;
                        r_wr_state <= WR_IDLE;
                    end
                end
                default: begin
                    r_awready  <= 1'b0;
                    r_wready   <= 1'b0;
                    r_bvalid   <= 1'b0;
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    // Burst bookkeeping; only meaningful while the engine is busy.
    always_ff @(posedge aclk) begin
        if (w_aw_hs) begin
            r_wr_idx <= s_axi_awaddr[OFF_W +: IDX_W];
            r_wr_len <= s_axi_awlen;
            r_wr_cnt <= 8'd0;
        end else if (w_w_hs) begin
            r_wr_idx <= r_wr_idx + IDX_W'(1);
            r_wr_cnt <= r_wr_cnt + 8'd1;
        end
    end

    // Byte-enabled memory write; index wraps naturally modulo the depth.
    always_ff @(posedge aclk) begin
        if (w_w_hs && !areset) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[r_wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------------
    rd_state_t         r_rd_state;
    logic              r_arready;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [8:0]        r_rd_left;

    // Two-entry output skid: memory reads land directly in a slot, so the
    // synchronous read register is also the first output stage.
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rd_data_p1 [2];
    logic                          r_rd_last_p1 [2];
    logic                          r_rd_wptr_p1;
    logic                          r_rd_rptr_p1;
    logic [1:0]                    r_rd_cnt_p1;

    logic w_ar_hs;
    logic w_rd_issue;
    logic w_rvalid;
    logic w_r_pop;
    logic w_r_last_hs;

    assign w_ar_hs     = s_axi_arvalid && r_arready;
    assign w_rvalid    = (r_rd_cnt_p1 != 2'd0);
    assign w_r_pop     = w_rvalid && s_axi_rready;
    assign w_r_last_hs = w_r_pop && r_rd_last_p1[r_rd_rptr_p1];

    // Issue a read only if its result has a slot when it lands; a pop in the
    // same cycle frees one, which keeps full rate under continuous rready.
    assign w_rd_issue  = (r_rd_state == RD_BURST) && (r_rd_left != 9'd0) &&
                         ((r_rd_cnt_p1 != 2'd2) || w_r_pop);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_state   <= RD_IDLE;
            r_arready    <= 1'b0;
            r_rd_wptr_p1 <= 1'b0;
            r_rd_rptr_p1 <= 1'b0;
            r_rd_cnt_p1  <= 2'd0;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready  <= 1'b0;
                        r_rd_state <= RD_BURST;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                RD_BURST: begin
                    if (w_r_last_hs) begin
                        r_arready  <= 1'b1;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: begin
                    r_arready  <= 1'b0;
                    r_rd_state <= RD_IDLE;
                end
            endcase

            if (w_rd_issue) begin
                r_rd_wptr_p1 <= ~r_rd_wptr_p1;
            end
            if (w_r_pop) begin
                r_rd_rptr_p1 <= ~r_rd_rptr_p1;
            end
            case ({w_rd_issue, w_r_pop})
                2'b10:   r_rd_cnt_p1 <= r_rd_cnt_p1 + 2'd1;
                2'b01:   r_rd_cnt_p1 <= r_rd_cnt_p1 - 2'd1;
                default: r_rd_cnt_p1 <= r_rd_cnt_p1;
            endcase
        end
    end

    // Burst bookkeeping: r_rd_left counts beats still to be fetched.
    always_ff @(posedge aclk) begin
        if (w_ar_hs) begin
            r_rd_idx  <= s_axi_araddr[OFF_W +: IDX_W];
            r_rd_left <= {1'b0, s_axi_arlen} + 9'd1;
        end else if (w_rd_issue) begin
            r_rd_idx  <= r_rd_idx + IDX_W'(1);
            r_rd_left <= r_rd_left - 9'd1;
        end
    end

    // --- stage p1: synchronous memory read into the skid slot ---
    // Non-blocking read against the non-blocking write above gives read-first
    // behaviour on a same-cycle collision.
    always_ff @(posedge aclk) begin
        if (w_rd_issue) begin
            r_rd_data_p1[r_rd_wptr_p1] <= r_mem[r_rd_idx];
            r_rd_last_p1[r_rd_wptr_p1] <= (r_rd_left == 9'd1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_axi_awready  = r_awready;
    assign s_axi_wready   = r_wready;
    assign s_axi_bvalid   = r_bvalid;
    assign s_axi_arready  = r_arready;
    assign s_axi_rvalid   = w_rvalid;
    // Gated so data/last read as zero whenever nothing is being presented.
    assign s_axi_rdata    = w_rvalid ? r_rd_data_p1[r_rd_rptr_p1] : '0;
    assign s_axi_rlast    = w_rvalid && r_rd_last_p1[r_rd_rptr_p1];
    assign stat_wlast_err = r_wlast_err;

endmodule

// File: tb/tb_cceip_kernel_example_axi_mem_responder.sv
module tb_cceip_kernel_example_axi_mem_responder;

    localparam int AW    = 64;
    localparam int DW    = 512;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;

    logic            aclk = 1'b0;
    logic            areset;
    logic            s_axi_awvalid, s_axi_awready;
    logic [AW-1:0]   s_axi_awaddr;
    logic [7:0]      s_axi_awlen;
    logic            s_axi_wvalid, s_axi_wready;
    logic [DW-1:0]   s_axi_wdata;
    logic [SW-1:0]   s_axi_wstrb;
    logic            s_axi_wlast;
    logic            s_axi_bvalid, s_axi_bready;
    logic            s_axi_arvalid, s_axi_arready;
    logic [AW-1:0]   s_axi_araddr;
    logic [7:0]      s_axi_arlen;
    logic            s_axi_rvalid, s_axi_rready;
    logic [DW-1:0]   s_axi_rdata;
    logic            s_axi_rlast;
    logic            stat_wlast_err;

    always #5 aclk = ~aclk;

    cceip_kernel_example_axi_mem_responder #(
        .C_S_AXI_ADDR_WIDTH (AW),
        .C_S_AXI_DATA_WIDTH (DW),
        .C_MEM_DEPTH_WORDS  (DEPTH)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awlen    (s_axi_awlen),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wstrb    (s_axi_wstrb),
        .s_axi_wlast    (s_axi_wlast),
        .s_axi_bvalid   (s_axi_bvalid),
        .s_axi_bready   (s_axi_bready),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arlen    (s_axi_arlen),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rlast    (s_axi_rlast),
        .stat_wlast_err (stat_wlast_err)
    );

    // Reference model: plain word array, updated at every accepted W beat.
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } rbeat_t;

    logic [DW-1:0] m_mem [DEPTH];
    rbeat_t        exp_q [$];
    logic [DW-1:0] wbuf  [256];
    logic [SW-1:0] sbuf  [256];

    int vectors     = 0;
    int miscompares = 0;
    int b_issued    = 0;
    int b_seen      = 0;
    int r_hs_cnt    = 0;
    int rmode       = 0;   // 0: rready=1, 1: pattern 1,0,0, 2: random
    int bmode       = 0;   // 0: bready=1, 1: random

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting, required event never seen", name);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Random upper and byte-offset bits around a word index; the DUT must ignore them.
    function automatic logic [AW-1:0] mk_addr(input int word);
        logic [31:0] r1, r2, r3;
        logic [9:0]  w;
        r1 = $urandom();
        r2 = $urandom();
        r3 = $urandom();
        w  = word[9:0];
        return {r1, r2[15:0], w, r3[5:0]};
    endfunction

    function automatic int word_of(input logic [AW-1:0] addr);
        return int'((addr >> 6) % 64'd1024);
    endfunction

    // Ready drivers for the response channels.
    initial begin
        int rpat;
        rpat = 0;
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
        forever begin
            tick();
            case (rmode)
                0:       s_axi_rready = 1'b1;
                1:       begin s_axi_rready = (rpat % 3 == 0); rpat++; end
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            s_axi_bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every R handshake, checks holds under stall.
    logic          p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0;
    logic [DW-1:0] p_data = '0;
    always @(negedge aclk) begin
        if (areset) begin
            p_vld = 1'b0;
        end else begin
            if (p_vld && !p_rdy) begin
                chk1("r_hold_valid", s_axi_rvalid, 1'b1);
                chk("r_hold_data", s_axi_rdata, p_data);
                chk1("r_hold_last", s_axi_rlast, p_last);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_q.size() == 0) begin
                    fail_to("r_unexpected_beat");
                end else begin
                    rbeat_t e;
                    e = exp_q.pop_front();
                    chk("r_data", s_axi_rdata, e.data);
                    chk1("r_last", s_axi_rlast, e.last);
                end
                r_hs_cnt++;
            end
            if (s_axi_bvalid && s_axi_bready) begin
                chk1("b_expected", b_issued > b_seen, 1'b1);
                b_seen++;
            end
            p_vld  = s_axi_rvalid;
            p_rdy  = s_axi_rready;
            p_data = s_axi_rdata;
            p_last = s_axi_rlast;
        end
    end

    task automatic aw_req(input logic [AW-1:0] addr, input int len);
        int t;
        t = 0;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready) begin
            tick();
            t++;
            if (t > 2000) begin fail_to("awready"); break; end
        end
        tick();
        s_axi_awvalid = 1'b0;
        chk1("wready_after_aw", s_axi_wready, 1'b1);
    endtask

    task automatic w_beats(input int word, input int len, input int bad, input bit gaps);
        int t;
        for (int k = 0; k <= len; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                tick();
            end
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wbuf[k];
            s_axi_wstrb  = sbuf[k];
            s_axi_wlast  = (k == len) != (k == bad);
            t = 0;
            while (!s_axi_wready) begin
                tick();
                t++;
                if (t > 2000) begin fail_to("wready"); break; end
            end
            for (int b = 0; b < SW; b++)
                if (sbuf[k][b]) m_mem[(word + k) % DEPTH][8*b +: 8] = wbuf[k][8*b +: 8];
            tick();
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        b_issued++;
        chk1("bvalid_after_last_w", s_axi_bvalid, 1'b1);
        chk1("wready_low_in_resp", s_axi_wready, 1'b0);
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int len, input int bad, input bit gaps);
        aw_req(addr, len);
        w_beats(word_of(addr), len, bad, gaps);
    endtask

    task automatic ar_req(input logic [AW-1:0] addr, input int len);
        int t, word;
        rbeat_t e;
        word = word_of(addr);
        t = 0;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready) begin
            tick();
            t++;
            if (t > 2000) begin fail_to("arready"); break; end
        end
        for (int k = 0; k <= len; k++) begin
            e.data = m_mem[(word + k) % DEPTH];
            e.last = (k == len);
            exp_q.push_back(e);
        end
        tick();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 || b_issued != b_seen || !s_axi_awready || !s_axi_arready) begin
            tick();
            t++;
            if (t > 5000) begin
                fail_to("idle");
                exp_q.delete();
                b_issued = b_seen;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        areset        = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
        repeat (3) tick();

        // Reset values
        chk1("rst_awready", s_axi_awready, 1'b0);
        chk1("rst_wready",  s_axi_wready,  1'b0);
        chk1("rst_bvalid",  s_axi_bvalid,  1'b0);
        chk1("rst_arready", s_axi_arready, 1'b0);
        chk1("rst_rvalid",  s_axi_rvalid,  1'b0);
        chk1("rst_rlast",   s_axi_rlast,   1'b0);
        chk("rst_rdata",    s_axi_rdata,   '0);
        chk1("rst_stat",    stat_wlast_err, 1'b0);
        areset = 1'b0;
        tick();
        chk1("arready_after_release", s_axi_arready, 1'b1);
        chk1("awready_after_release", s_axi_awready, 1'b1);

        // Fill whole memory so every later read has defined data
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 256; k++) begin wbuf[k] = rand_word(); sbuf[k] = '1; end
            wr_burst(mk_addr(blk * 256), 255, -1, 0);
        end
        wait_idle();

        // Directed 4-beat write/read at 0x40 with latency checks
        for (int k = 0; k < 4; k++) begin wbuf[k] = '0; wbuf[k][7:0] = 8'hA0 + 8'(k); sbuf[k] = '1; end
        wr_burst(64'h40, 3, -1, 0);
        wait_idle();
        ar_req(64'h40, 3);
        chk1("r_T1_no_valid", s_axi_rvalid, 1'b0);
        tick();
        chk1("r_T2_valid", s_axi_rvalid, 1'b1);
        chk1("r_T2_not_last", s_axi_rlast, 1'b0);
        repeat (3) tick();
        chk1("r_T5_last", s_axi_rlast, 1'b1);
        chk1("arready_T5_low", s_axi_arready, 1'b0);
        tick();
        chk1("arready_T6_high", s_axi_arready, 1'b1);
        wait_idle();

        // Partial strobe
        bmode = 1;
        wbuf[0] = '1; sbuf[0] = '1;
        wr_burst(mk_addr(7), 0, -1, 0);
        wbuf[0] = '0; sbuf[0] = 64'h1;
        wr_burst(mk_addr(7), 0, -1, 0);
        wait_idle();
        ar_req(mk_addr(7), 0);
        wait_idle();

        // Backpressure 1,0,0 pattern on an 8-beat read
        rmode = 1;
        ar_req(mk_addr(100), 7);
        wait_idle();
        rmode = 0;

        // Wrap at the top of memory
        wbuf[0] = rand_word(); wbuf[1] = rand_word(); sbuf[0] = '1; sbuf[1] = '1;
        wr_burst(mk_addr(1023), 1, -1, 0);
        wait_idle();
        ar_req(mk_addr(0), 0);
        ar_req(mk_addr(1023), 1);
        wait_idle();

        // wlast auditing
        wbuf[0] = rand_word(); sbuf[0] = '1;
        wr_burst(mk_addr(300), 0, -1, 0);
        wait_idle();
        chk1("stat_clean_len0", stat_wlast_err, 1'b0);
        for (int k = 0; k < 3; k++) begin wbuf[k] = rand_word(); sbuf[k] = '1; end
        wr_burst(mk_addr(310), 2, 1, 0);
        wait_idle();
        chk1("stat_set_early_wlast", stat_wlast_err, 1'b1);
        ar_req(mk_addr(310), 2);
        wait_idle();

        // Same-word read/write collision: read samples memory in the cycle the write lands
        wbuf[0] = rand_word(); sbuf[0] = '1;
        aw_req(mk_addr(500), 0);
        ar_req(mk_addr(500), 0);
        w_beats(500, 0, -1, 0);
        wait_idle();
        ar_req(mk_addr(500), 0);
        wait_idle();

        // Randomized traffic
        rmode = 2;
        for (int it = 0; it < 30; it++) begin
            int len;
            len = $urandom_range(0, 15);
            for (int k = 0; k <= len; k++) begin
                wbuf[k] = rand_word();
                sbuf[k] = ($urandom_range(0, 1) == 0) ? '1 : {$urandom(), $urandom()};
            end
            wr_burst(mk_addr($urandom_range(0, DEPTH - 1)), len, -1, 1);
            wait_idle();
            ar_req(mk_addr($urandom_range(0, DEPTH - 1)), $urandom_range(0, 15));
            wait_idle();
        end

        // Reset in the middle of an 8-beat read
        rmode = 0;
        base  = r_hs_cnt;
        ar_req(mk_addr(200), 7);
        t = 0;
        while (r_hs_cnt < base + 2) begin
            tick();
            t++;
            if (t > 100) begin fail_to("mid_burst_beats"); break; end
        end
        areset = 1'b1;
        exp_q.delete();
        tick();
        chk1("abort_rvalid",  s_axi_rvalid,  1'b0);
        chk1("abort_rlast",   s_axi_rlast,   1'b0);
        chk("abort_rdata",    s_axi_rdata,   '0);
        chk1("abort_arready", s_axi_arready, 1'b0);
        chk1("abort_awready", s_axi_awready, 1'b0);
        chk1("abort_stat",    stat_wlast_err, 1'b0);
        areset = 1'b0;
        tick();
        chk1("abort_arready_back", s_axi_arready, 1'b1);
        chk1("abort_no_rvalid",    s_axi_rvalid,  1'b0);
        ar_req(mk_addr(200), 1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
